// File: rtl/sram_burst_reader_pkg.sv
// Shared definitions for the SRAM burst reader.
//   - Default SRAM address/data widths. These must agree with the SRAM
//     controller and every other client of it.
//   - Default burst-length width and return-FIFO depth.
//   - Reader FSM state encoding.
package sram_burst_reader_pkg;

    localparam int SRAM_ADDR_BITS = 20;
    localparam int SRAM_DATA_BITS = 16;
    localparam int BURST_LEN_BITS = 16;
    localparam int RET_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/sram_burst_reader_fifo.sv
// sync_fifo: single-clock, first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   push_i/data_i  write side
//   pop_i          read side; pop while empty is ignored
//   data_o         head word, valid while empty_o is low
//   empty_o        FIFO holds no words
//   count_o        number of words held, 0..DEPTH
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // The writer must never push into a full buffer.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && count_q == FULL_CNT));

endmodule

// File: rtl/sram_burst_reader.sv
// sram_burst_reader: turns one (start_addr, len) command into len sequential
// single-word SRAM read requests, buffers the returned words and presents
// them as a valid/ready stream. Requests are credit-limited so that every
// word in flight already has a FIFO slot reserved.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, start_addr_i, len_i  burst command (taken only when idle)
//   busy_o, done_o                status; done_o pulses once per burst
//   m_valid_o, m_data_o, m_ready_i  output word stream
//   sram_*                        request/return port of the SRAM controller
module sram_burst_reader
    import sram_burst_reader_pkg::*;
#(
    parameter int ADDR_BITS  = SRAM_ADDR_BITS,
    parameter int DATA_BITS  = SRAM_DATA_BITS,
    parameter int LEN_BITS   = BURST_LEN_BITS,
    parameter int FIFO_DEPTH = RET_FIFO_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] start_addr_i,
    input  logic [LEN_BITS-1:0]  len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 m_valid_o,
    output logic [DATA_BITS-1:0] m_data_o,
    input  logic                 m_ready_i,
    output logic                 sram_req_o,
    input  logic                 sram_ready_i,
    output logic                 sram_write_enable_o,
    output logic [ADDR_BITS-1:0] sram_addr_o,
    output logic [DATA_BITS-1:0] sram_write_data_o,
    input  logic [DATA_BITS-1:0] sram_read_data_i,
    input  logic                 sram_read_data_valid_i
);

    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  rem_q, rem_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic                 done_q, done_d;
    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_empty;
    logic                 accept, rd_ok, credit_ok;

    // Words held plus words in flight must stay below the depth to issue.
    assign credit_ok  = ({1'b0, fifo_cnt} + {1'b0, outst_q}) < DEPTH_V;
    assign sram_req_o = (state_q == ST_ISSUE) && (rem_q != '0) && credit_ok;
    assign accept     = sram_req_o && sram_ready_i;
    // A return with nothing outstanding belongs to a burst killed by reset.
    assign rd_ok      = sram_read_data_valid_i && (outst_q != '0);

    assign busy_o              = (state_q != ST_IDLE);
    assign done_o              = done_q;
    assign m_valid_o           = !fifo_empty;
    assign sram_addr_o         = addr_q;
    assign sram_write_enable_o = 1'b0;
    assign sram_write_data_o   = '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case ({accept, rd_ok})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        addr_d  = start_addr_i;
                        rem_d   = len_i;
                        state_d = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_BITS'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Uses the next count so the last return finishes the burst
                // in the same cycle it lands in the FIFO.
                if (outst_d == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            outst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            outst_q <= outst_d;
            done_q  <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rd_ok),
        .data_i  (sram_read_data_i),
        .pop_i   (m_ready_i),
        .data_o  (m_data_o),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    a_outst_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        {1'b0, outst_q} <= DEPTH_V);

endmodule

// File: tb/tb_sram_burst_reader.sv
module tb_sram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [19:0] start_addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, m_valid, m_ready = 1'b0;
    logic [15:0] m_data;
    logic        sram_req, sram_ready, sram_we;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] rd_data = '0;
    logic        rd_valid = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_burst_reader dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .start_i                (start),
        .start_addr_i           (start_addr),
        .len_i                  (len),
        .busy_o                 (busy),
        .done_o                 (done),
        .m_valid_o              (m_valid),
        .m_data_o               (m_data),
        .m_ready_i              (m_ready),
        .sram_req_o             (sram_req),
        .sram_ready_i           (sram_ready),
        .sram_write_enable_o    (sram_we),
        .sram_addr_o            (sram_addr),
        .sram_write_data_o      (sram_wdata),
        .sram_read_data_i       (rd_data),
        .sram_read_data_valid_i (rd_valid)
    );

    // Memory contents: mem[0x100+i] = 0xA000+i, extended linearly everywhere.
    function automatic logic [15:0] memf(input logic [19:0] a);
        return 16'hA000 + a[15:0] - 16'h0100;
    endfunction

    // Controller model: one read at a time, data returns on the cycle after
    // the accept cycle's follower; best case one word per two clocks. It is
    // deliberately not reset with the reader, so stale returns can occur.
    logic        pend_q = 1'b0;
    logic [19:0] pend_a = '0;
    assign sram_ready = !pend_q;
    always @(posedge clk) begin
        rd_valid <= 1'b0;
        if (pend_q) begin
            rd_valid <= 1'b1;
            rd_data  <= memf(pend_a);
            pend_q   <= 1'b0;
        end
        if (sram_req && sram_ready) begin
            pend_q <= 1'b1;
            pend_a <= sram_addr;
        end
    end

    logic [15:0] got_q[$];
    logic [19:0] acc_q[$];
    int n_done, req_seen, busy_with_done;
    bit rnd_rdy = 1'b0;

    task automatic clear_mon();
        got_q.delete();
        acc_q.delete();
        n_done = 0;
        req_seen = 0;
        busy_with_done = 0;
    endtask

    // One clock: observe at the falling edge, change inputs just after the rise.
    task automatic cyc();
        @(negedge clk);
        if (m_valid && m_ready) got_q.push_back(m_data);
        if (sram_req && sram_ready) acc_q.push_back(sram_addr);
        if (sram_req) req_seen++;
        if (done) begin
            n_done++;
            if (busy) busy_with_done++;
        end
        @(posedge clk);
        #1;
        if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic go(input logic [19:0] a, input logic [15:0] l);
        start = 1'b1; start_addr = a; len = l;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget, input string nm);
        int i;
        for (i = 0; i < budget && !(got_q.size() >= n && !busy && n_done > 0); i++) cyc();
        n_checks++;
        if (i >= budget) begin
            n_errors++;
            $display("FAIL %s_timeout: got %0d words done=%0d, need %0d words", nm, got_q.size(), n_done, n);
        end
        repeat (4) cyc();
    endtask

    task automatic check_words(input string nm, input logic [19:0] a, input int n);
        n_checks++;
        if (got_q.size() != n) begin
            n_errors++;
            $display("FAIL %s_count: got %0d words, expected %0d", nm, got_q.size(), n);
        end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== memf(a + 20'(i))) begin
                n_errors++;
                $display("FAIL %s_data[%0d]: got %h expected %h", nm, i, got_q[i], memf(a + 20'(i)));
            end
        end
    endtask

    task automatic check_outputs_reset(input string nm);
        n_checks++;
        if ({busy, done, m_valid, sram_req, sram_addr} !== 24'h0) begin
            n_errors++;
            $display("FAIL %s: busy=%b done=%b m_valid=%b req=%b addr=%h, expected all 0",
                     nm, busy, done, m_valid, sram_req, sram_addr);
        end
        n_checks++;
        if ({sram_we, sram_wdata} !== 17'h0) begin
            n_errors++;
            $display("FAIL %s_tied: we=%b wdata=%h expected 0", nm, sram_we, sram_wdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_outputs_reset("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) cyc();
    endtask

    task automatic test_basic();
        rnd_rdy = 1'b1;
        clear_mon();
        go(20'h00100, 16'd4);
        run_until(4, 200, "basic");
        check_words("basic", 20'h00100, 4);
        n_checks++;
        if (n_done !== 1) begin
            n_errors++;
            $display("FAIL basic_done: got %0d pulses, expected 1", n_done);
        end
        n_checks++;
        if (busy_with_done !== 0) begin
            n_errors++;
            $display("FAIL basic_busy_falls: busy high on %0d done cycles, expected 0", busy_with_done);
        end
    endtask

    task automatic test_credit();
        rnd_rdy = 1'b0;
        m_ready = 1'b0;
        clear_mon();
        go(20'h00200, 16'd20);
        repeat (60) cyc();
        n_checks++;
        if (acc_q.size() != 8) begin
            n_errors++;
            $display("FAIL credit_accepts: got %0d, expected 8", acc_q.size());
        end
        n_checks++;
        if (sram_req !== 1'b0 || m_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL credit_stall: req=%b m_valid=%b, expected req=0 m_valid=1", sram_req, m_valid);
        end
        m_ready = 1'b1;
        rnd_rdy = 1'b1;
        run_until(20, 600, "credit");
        check_words("credit", 20'h00200, 20);
        n_checks++;
        if (n_done !== 1) begin
            n_errors++;
            $display("FAIL credit_done: got %0d pulses, expected 1", n_done);
        end
    endtask

    task automatic test_wrap();
        logic [19:0] exp_a[4];
        exp_a[0] = 20'hFFFFE; exp_a[1] = 20'hFFFFF; exp_a[2] = 20'h00000; exp_a[3] = 20'h00001;
        rnd_rdy = 1'b1;
        clear_mon();
        go(20'hFFFFE, 16'd4);
        run_until(4, 200, "wrap");
        n_checks++;
        if (acc_q.size() != 4) begin
            n_errors++;
            $display("FAIL wrap_accepts: got %0d, expected 4", acc_q.size());
        end
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            n_checks++;
            if (acc_q[i] !== exp_a[i]) begin
                n_errors++;
                $display("FAIL wrap_addr[%0d]: got %h expected %h", i, acc_q[i], exp_a[i]);
            end
        end
        check_words("wrap", 20'hFFFFE, 4);
    endtask

    task automatic test_len0();
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        clear_mon();
        start = 1'b1; start_addr = 20'h12345; len = 16'd0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL len0_done_early: got %b expected 0", done);
        end
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL len0_done: done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        cyc();
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++;
            $display("FAIL len0_one_cycle: done=%b expected 0", done);
        end
        repeat (5) cyc();
        n_checks++;
        if (req_seen !== 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL len0_no_req: req cycles=%0d busy=%b expected 0/0", req_seen, busy);
        end
    endtask

    task automatic test_busy_start();
        rnd_rdy = 1'b1;
        clear_mon();
        go(20'h00300, 16'd6);
        repeat (3) cyc();
        go(20'h00400, 16'd5);
        run_until(6, 300, "busystart");
        check_words("busystart", 20'h00300, 6);
        n_checks++;
        if (n_done !== 1 || acc_q.size() != 6) begin
            n_errors++;
            $display("FAIL busystart_ignored: done=%0d accepts=%0d expected 1/6", n_done, acc_q.size());
        end
    endtask

    task automatic test_back_to_back();
        rnd_rdy = 1'b0;
        m_ready = 1'b0;
        clear_mon();
        go(20'h00700, 16'd3);
        for (int i = 0; i < 100 && busy; i++) cyc();
        go(20'h00710, 16'd3);
        for (int i = 0; i < 100 && busy; i++) cyc();
        n_checks++;
        if (busy !== 1'b0 || n_done < 1) begin
            n_errors++;
            $display("FAIL b2b_bursts: busy=%b done=%0d expected 0/>=1", busy, n_done);
        end
        m_ready = 1'b1;
        repeat (12) cyc();
        n_checks++;
        if (got_q.size() != 6) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d words expected 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== memf((i < 3) ? 20'h00700 + 20'(i) : 20'h0070D + 20'(i))) begin
                n_errors++;
                $display("FAIL b2b_data[%0d]: got %h", i, got_q[i]);
            end
        end
        n_checks++;
        if (n_done !== 2) begin
            n_errors++;
            $display("FAIL b2b_done: got %0d pulses expected 2", n_done);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        rnd_rdy = 1'b0;
        m_ready = 1'b1;
        clear_mon();
        go(20'h00500, 16'd10);
        for (i = 0; i < 60 && acc_q.size() < 3; i++) cyc();
        n_checks++;
        if (acc_q.size() != 3) begin
            n_errors++;
            $display("FAIL rstmid_setup: got %0d accepts expected 3", acc_q.size());
        end
        rst_n = 1'b0;
        #1;
        check_outputs_reset("rstmid");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) cyc();
        clear_mon();
        go(20'h00600, 16'd2);
        run_until(2, 200, "rstmid_new");
        check_words("rstmid_new", 20'h00600, 2);
        n_checks++;
        if (n_done !== 1) begin
            n_errors++;
            $display("FAIL rstmid_done: got %0d pulses expected 1", n_done);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_credit();
        test_wrap();
        test_len0();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
